ucsbece154b_fetch_queue: RTL and testbench

//  Dual-issue instruction queue between fetch and the two decode slots. Takes up to 2 instrs/cycle from imem.

---
 rtl/ucsbece154b_fetch_queue_pkg.sv | 35 +++
 rtl/ucsbece154b_fq_mem.sv | 37 +++
 rtl/ucsbece154b_fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_ucsbece154b_fetch_queue.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_fetch_queue_pkg.sv
// Shared definitions for the dual-issue fetch queue: NOP encoding, entry layout
// {PredTaken, PC[31:0], Instr[31:0]} and the decode pop rule.
package ucsbece154b_fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int PRED_W  = 1;
    localparam int ENTRY_W = PRED_W + PC_W + INSTR_W;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic               pred;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Number of slots decode consumes this cycle:
    // load-use stall holds everything, a dual-issue hazard (or a missing
    // slot 2) lets only slot 1 go, otherwise both slots retire.
    function automatic logic [1:0] fq_pop_count(input logic stall_d,
                                                input logic stall_d2,
                                                input logic valid_d,
                                                input logic valid_d2);
        logic [1:0] n;
        if (stall_d)
            n = 2'd0;
        else if (stall_d2 || !valid_d2)
            n = {1'b0, valid_d};
        else
            n = 2'd2;
        return n;
    endfunction

endpackage

// File: rtl/ucsbece154b_fq_mem.sv
// Fetch queue storage: DEPTH x 65-bit register array with two write ports
// (port 1 only writes alongside port 0) and two asynchronous read ports.
// Data is intentionally not reset; validity lives in the top's count.
module ucsbece154b_fq_mem
    import ucsbece154b_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_waddr0,
    input  logic [AW-1:0] i_waddr1,
    input  fq_entry_t     i_wdata0,
    input  fq_entry_t     i_wdata1,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    output fq_entry_t     o_rdata0,
    output fq_entry_t     o_rdata1
);

    fq_entry_t r_mem [DEPTH];

    // Write the first word, and the second only when the first is written too.
    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
            if (i_we1)
                r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/ucsbece154b_fetch_queue.sv
// Dual-issue instruction queue between fetch and the two decode slots.
// Optional same-cycle fetch-to-decode bypass when empty: FETCHQ_BYPASS_EN.
module ucsbece154b_fetch_queue
    import ucsbece154b_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  FetchValid_i,
    input  logic [31:0] FetchPC_i,
    input  logic [31:0] FetchInstr0_i,
    input  logic [31:0] FetchInstr1_i,
    input  logic [1:0]  FetchPredTaken_i,
    output logic        FetchReady_o,
    input  logic        StallD_i,
    input  logic        StallD2_i,
    input  logic        Mispredict_i,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCD_o,
    output logic        PredTakenD_o,
    output logic        ValidD_o,
    output logic [31:0] InstrD2_o,
    output logic [31:0] PCD2_o,
    output logic        PredTakenD2_o,
    output logic        ValidD2_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    // Handshake: a fetch word transfers on a rising edge where FetchValid_i
    // marks it and FetchReady_o is high. FetchReady_o depends only on the
    // registered count (room for a full 2-wide push), never on this cycle's
    // stalls or mispredict, so fetch sees no combinational path from decode.
    // Words offered while FetchReady_o is low are dropped, not held.
    logic w_fetch_ready;
    logic w_push_en;
    logic [1:0] w_push_n;
    assign w_fetch_ready = (r_count <= CW'(DEPTH - 2));
    assign w_push_en     = w_fetch_ready & FetchValid_i[0];
    assign w_push_n      = w_push_en ? (FetchValid_i[1] ? 2'd2 : 2'd1) : 2'd0;
    assign FetchReady_o  = w_fetch_ready;

    fq_entry_t w_entry0, w_entry1;
    assign w_entry0 = {FetchPredTaken_i[0], FetchPC_i, FetchInstr0_i};
    assign w_entry1 = {FetchPredTaken_i[1], FetchPC_i + 32'd4, FetchInstr1_i};

    fq_entry_t w_q0, w_q1;
    logic [AW-1:0] w_rd_ptr1, w_wr_ptr1;
    assign w_rd_ptr1 = r_rd_ptr + AW'(1);
    assign w_wr_ptr1 = r_wr_ptr + AW'(1);

    logic      w_slot_v, w_slot_v2;
    fq_entry_t w_slot_e, w_slot_e2;
    logic [1:0] w_pop;
    logic       w_we0, w_we1;
    fq_entry_t  w_wd0, w_wd1;
    logic [1:0] w_rd_adv, w_wr_adv;

`ifdef FETCHQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass = (r_count == '0) && w_fetch_ready;
`endif

    // Select what the decode slots see: queue head, or raw fetch words when bypassing.
    always_comb begin
        w_slot_v  = (r_count >= CW'(1));
        w_slot_v2 = (r_count >= CW'(2));
        w_slot_e  = w_q0;
        w_slot_e2 = w_q1;
`ifdef FETCHQ_BYPASS_EN
        if (w_bypass) begin
            w_slot_v  = FetchValid_i[0];
            w_slot_v2 = FetchValid_i[0] & FetchValid_i[1];
            w_slot_e  = w_entry0;
            w_slot_e2 = w_entry1;
        end
`endif
    end

    assign ValidD_o      = w_slot_v;
    assign InstrD_o      = w_slot_v ? w_slot_e.instr : NOP_INSTR;
    assign PCD_o         = w_slot_v ? w_slot_e.pc : 32'd0;
    assign PredTakenD_o  = w_slot_v & w_slot_e.pred;
    assign ValidD2_o     = w_slot_v2;
    assign InstrD2_o     = w_slot_v2 ? w_slot_e2.instr : NOP_INSTR;
    assign PCD2_o        = w_slot_v2 ? w_slot_e2.pc : 32'd0;
    assign PredTakenD2_o = w_slot_v2 & w_slot_e2.pred;

    // Decide pop count, storage writes and pointer advances for this cycle.
    always_comb begin
        w_pop    = fq_pop_count(StallD_i, StallD2_i, w_slot_v, w_slot_v2);
        w_we0    = w_push_en;
        w_we1    = w_push_en & FetchValid_i[1];
        w_wd0    = w_entry0;
        w_wd1    = w_entry1;
        w_rd_adv = w_pop;
        w_wr_adv = w_push_n;
`ifdef FETCHQ_BYPASS_EN
        // Bypassed words already consumed by decode never enter storage;
        // the leftover word (if any) lands at wr_ptr.
        if (w_bypass) begin
            w_rd_adv = 2'd0;
            w_wr_adv = w_push_n - w_pop;
            if (w_pop == 2'd1) begin
                w_we0 = (w_push_n == 2'd2);
                w_we1 = 1'b0;
                w_wd0 = w_entry1;
            end else if (w_pop == 2'd2) begin
                w_we0 = 1'b0;
                w_we1 = 1'b0;
            end
        end
`endif
    end

    ucsbece154b_fq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .i_we0    (w_we0 & reset & ~Mispredict_i),
        .i_we1    (w_we1 & reset & ~Mispredict_i),
        .i_waddr0 (r_wr_ptr),
        .i_waddr1 (w_wr_ptr1),
        .i_wdata0 (w_wd0),
        .i_wdata1 (w_wd1),
        .i_raddr0 (r_rd_ptr),
        .i_raddr1 (w_rd_ptr1),
        .o_rdata0 (w_q0),
        .o_rdata1 (w_q1)
    );

    // Pointer/count update; mispredict discards everything including this cycle's fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (Mispredict_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_rd_adv);
            r_wr_ptr <= r_wr_ptr + AW'(w_wr_adv);
            r_count  <= r_count + CW'(w_push_n) - CW'(w_pop);
        end
    end

`ifdef SIM
    // Flag fetch pushing into a queue without room; the words are dropped.
    always_ff @(posedge clk) begin
        if (reset && !Mispredict_i && FetchValid_i[0] && !w_fetch_ready)
            $error("fetch_queue: push while FetchReady_o=0 dropped");
    end
`endif

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// Directed self-checking bench for ucsbece154b_fetch_queue (DEPTH=8).
module tb_ucsbece154b_fetch_queue;

    logic        clk;
    logic        reset;
    logic [1:0]  FetchValid_i;
    logic [31:0] FetchPC_i;
    logic [31:0] FetchInstr0_i;
    logic [31:0] FetchInstr1_i;
    logic [1:0]  FetchPredTaken_i;
    logic        FetchReady_o;
    logic        StallD_i;
    logic        StallD2_i;
    logic        Mispredict_i;
    logic [31:0] InstrD_o;
    logic [31:0] PCD_o;
    logic        PredTakenD_o;
    logic        ValidD_o;
    logic [31:0] InstrD2_o;
    logic [31:0] PCD2_o;
    logic        PredTakenD2_o;
    logic        ValidD2_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    ucsbece154b_fetch_queue #(.DEPTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .FetchValid_i     (FetchValid_i),
        .FetchPC_i        (FetchPC_i),
        .FetchInstr0_i    (FetchInstr0_i),
        .FetchInstr1_i    (FetchInstr1_i),
        .FetchPredTaken_i (FetchPredTaken_i),
        .FetchReady_o     (FetchReady_o),
        .StallD_i         (StallD_i),
        .StallD2_i        (StallD2_i),
        .Mispredict_i     (Mispredict_i),
        .InstrD_o         (InstrD_o),
        .PCD_o            (PCD_o),
        .PredTakenD_o     (PredTakenD_o),
        .ValidD_o         (ValidD_o),
        .InstrD2_o        (InstrD2_o),
        .PCD2_o           (PCD2_o),
        .PredTakenD2_o    (PredTakenD2_o),
        .ValidD2_o        (ValidD2_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A50000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        FetchValid_i     = 2'b00;
        FetchPC_i        = 32'd0;
        FetchInstr0_i    = 32'd0;
        FetchInstr1_i    = 32'd0;
        FetchPredTaken_i = 2'b00;
        Mispredict_i     = 1'b0;
    endtask

    task automatic drive_push(input logic [1:0] v, input logic [31:0] pc, input logic [1:0] pred);
        FetchValid_i     = v;
        FetchPC_i        = pc;
        FetchInstr0_i    = instr_of(pc);
        FetchInstr1_i    = instr_of(pc + 32'd4);
        FetchPredTaken_i = pred;
    endtask

    task automatic flush();
        drive_idle();
        Mispredict_i = 1'b1;
        tick();
        Mispredict_i = 1'b0;
    endtask

    initial begin : main
        int mcnt;
        int eff;
        int pop;
        int pushn;
        logic [31:0] next_pc;

        // Reset
        reset = 1'b0;
        StallD_i = 1'b0;
        StallD2_i = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("rst_valid", {31'd0, ValidD_o}, 32'd0);
        chk("rst_valid2", {31'd0, ValidD2_o}, 32'd0);
        chk("rst_instr", InstrD_o, 32'h00000013);
        chk("rst_instr2", InstrD2_o, 32'h00000013);
        chk("rst_pc", PCD_o, 32'd0);
        chk("rst_pred", {31'd0, PredTakenD_o}, 32'd0);
        chk("rst_ready", {31'd0, FetchReady_o}, 32'd1);

        // 1: dual push at PC 0, visible next cycle, then dual pop
        FetchValid_i     = 2'b11;
        FetchPC_i        = 32'h0;
        FetchInstr0_i    = 32'h00500093;
        FetchInstr1_i    = 32'h00600113;
        FetchPredTaken_i = 2'b10;
        #1;
`ifdef FETCHQ_BYPASS_EN
        chk("t1_bypass_same_cycle", {31'd0, ValidD_o}, 32'd1);
`else
        chk("t1_no_same_cycle", {31'd0, ValidD_o}, 32'd0);
`endif
        StallD_i = 1'b1;
        tick();
        drive_idle();
        StallD_i = 1'b0;
        chk("t1_valid", {31'd0, ValidD_o}, 32'd1);
        chk("t1_valid2", {31'd0, ValidD2_o}, 32'd1);
        chk("t1_pc", PCD_o, 32'h0);
        chk("t1_pc2", PCD2_o, 32'h4);
        chk("t1_instr", InstrD_o, 32'h00500093);
        chk("t1_instr2", InstrD2_o, 32'h00600113);
        chk("t1_pred", {31'd0, PredTakenD_o}, 32'd0);
        chk("t1_pred2", {31'd0, PredTakenD2_o}, 32'd1);
        tick();
        chk("t1_empty_after_pop", {31'd0, ValidD_o}, 32'd0);
        chk("t1_ready_after_pop", {31'd0, FetchReady_o}, 32'd1);

        // 2: A,B,C queued; slot-2 hazard pops only A
        StallD_i = 1'b1;
        drive_push(2'b11, 32'h100, 2'b00);
        tick();
        drive_push(2'b01, 32'h108, 2'b00);
        tick();
        drive_idle();
        StallD_i = 1'b0;
        StallD2_i = 1'b1;
        #1;
        chk("t2_head_a", PCD_o, 32'h100);
        tick();
        StallD_i = 1'b1;
        StallD2_i = 1'b0;
        chk("t2_slot1_b", PCD_o, 32'h104);
        chk("t2_slot2_c", PCD2_o, 32'h108);
        chk("t2_instr_b", InstrD_o, instr_of(32'h104));
        flush();
        chk("t2_flushed", {31'd0, ValidD_o}, 32'd0);

        // 3: fill to DEPTH, extra push ignored, dual pop reopens
        for (int k = 0; k < 4; k++) begin
            drive_push(2'b11, 32'h200 + 32'(k * 8), 2'b00);
            tick();
        end
        drive_idle();
        chk("t3_full_not_ready", {31'd0, FetchReady_o}, 32'd0);
        drive_push(2'b11, 32'h300, 2'b00);
        tick();
        drive_idle();
        chk("t3_head_kept", PCD_o, 32'h200);
        chk("t3_head2_kept", PCD2_o, 32'h204);
        chk("t3_still_full", {31'd0, FetchReady_o}, 32'd0);
        StallD_i = 1'b0;
        tick();
        StallD_i = 1'b1;
        chk("t3_ready_after_pop", {31'd0, FetchReady_o}, 32'd1);
        chk("t3_head_after_pop", PCD_o, 32'h208);
        flush();

        // 4: count=5, mispredict with same-cycle push
        drive_push(2'b11, 32'h400, 2'b00);
        tick();
        drive_push(2'b11, 32'h408, 2'b00);
        tick();
        drive_push(2'b01, 32'h410, 2'b00);
        tick();
        chk("t4_count5_head", PCD_o, 32'h400);
        drive_push(2'b11, 32'h500, 2'b11);
        Mispredict_i = 1'b1;
        StallD_i = 1'b0;
        tick();
        drive_idle();
        StallD_i = 1'b1;
        chk("t4_valid", {31'd0, ValidD_o}, 32'd0);
        chk("t4_valid2", {31'd0, ValidD2_o}, 32'd0);
        chk("t4_instr_nop", InstrD_o, 32'h00000013);
        chk("t4_pc", PCD_o, 32'd0);
        chk("t4_ready", {31'd0, FetchReady_o}, 32'd1);
        tick();
        chk("t4_push_discarded", {31'd0, ValidD_o}, 32'd0);

`ifdef FETCHQ_BYPASS_EN
        // Bypass: empty queue plus push shows up in the same cycle
        drive_push(2'b11, 32'h600, 2'b00);
        #1;
        chk("bp_valid", {31'd0, ValidD_o}, 32'd1);
        chk("bp_pc", PCD_o, 32'h600);
        chk("bp_valid2", {31'd0, ValidD2_o}, 32'd1);
        chk("bp_pc2", PCD2_o, 32'h604);
        tick();
        drive_idle();
        chk("bp_stalled_kept", PCD_o, 32'h600);
        flush();
`endif

        // 5: sustained stream across pointer wrap, checked against a model
        mcnt = 0;
        next_pc = 32'h1000;
        for (int i = 0; i < 40; i++) begin
            StallD_i  = (i < 3);
            StallD2_i = ((i % 5) == 3);
            pushn = ((mcnt <= 6) && (i < 16)) ? 2 : 0;
            if (pushn == 2) drive_push(2'b11, next_pc, 2'b00);
            else drive_idle();
            #1;
            eff = mcnt;
`ifdef FETCHQ_BYPASS_EN
            if (mcnt == 0) begin
                eff = pushn;
                if (pushn == 2) begin
                    exp_q.push_back(next_pc);
                    exp_q.push_back(next_pc + 32'd4);
                end
            end
`endif
            chk("t5_ready", {31'd0, FetchReady_o}, {31'd0, (mcnt <= 6)});
            chk("t5_valid", {31'd0, ValidD_o}, {31'd0, (eff >= 1)});
            chk("t5_valid2", {31'd0, ValidD2_o}, {31'd0, (eff >= 2)});
            if (eff >= 1) begin
                chk("t5_pc", PCD_o, exp_q[0]);
                chk("t5_instr", InstrD_o, instr_of(exp_q[0]));
            end
            if (eff >= 2) chk("t5_pc2", PCD2_o, exp_q[1]);
            if (StallD_i) pop = 0;
            else if (StallD2_i || eff < 2) pop = (eff >= 1) ? 1 : 0;
            else pop = 2;
            for (int k = 0; k < pop; k++) void'(exp_q.pop_front());
`ifdef FETCHQ_BYPASS_EN
            if (mcnt != 0 && pushn == 2) begin
`else
            if (pushn == 2) begin
`endif
                exp_q.push_back(next_pc);
                exp_q.push_back(next_pc + 32'd4);
            end
            mcnt = mcnt + pushn - pop;
            if (pushn == 2) next_pc = next_pc + 32'd8;
            tick();
        end
        drive_idle();
        StallD2_i = 1'b0;
        chk("t5_drained", {31'd0, ValidD_o}, 32'd0);

        // 6: asynchronous reset mid-stream with count=3
        StallD_i = 1'b1;
        drive_push(2'b11, 32'h2000, 2'b00);
        tick();
        drive_push(2'b01, 32'h2008, 2'b00);
        tick();
        drive_idle();
        chk("t6_count3_head", PCD_o, 32'h2000);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", {31'd0, ValidD_o}, 32'd0);
        chk("t6_valid2", {31'd0, ValidD2_o}, 32'd0);
        chk("t6_ready", {31'd0, FetchReady_o}, 32'd1);
        chk("t6_instr_nop", InstrD_o, 32'h00000013);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_empty_after_release", {31'd0, ValidD_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
